// File: rtl/mont_pkg.sv
// Shared types and sizing helpers for the Montgomery multiplier.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } mont_state_e;

  // Headroom bits above WIDTH so acc + b + m never overflows before the shift.
  localparam int ACC_EXTRA = 2;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mont_iter_step.sv
// One radix-2 Montgomery iteration: adds the selected b and the reducing m,
// then halves. Purely combinational.
module mont_iter_step
  import mont_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH+ACC_EXTRA-1:0] acc_i,
  input  logic                       a_bit_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic [WIDTH-1:0]           m_i,
  output logic [WIDTH+ACC_EXTRA-1:0] acc_o
);

  localparam int AW = WIDTH + ACC_EXTRA;

  logic        q;
  logic [AW:0] sum;

  always_comb begin
    q     = acc_i[0] ^ (a_bit_i & b_i[0]);
    sum   = (AW+1)'(acc_i)
          + (a_bit_i ? (AW+1)'(b_i) : '0)
          + (q       ? (AW+1)'(m_i) : '0);
    acc_o = AW'(sum >> 1);
  end

endmodule

// File: rtl/mont_mul_engine.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m,
// WIDTH iterations plus one final conditional subtraction.
//
// state | meaning
// IDLE  | waiting for start; even modulus reported here with err/done
// RUN   | one iteration per cycle, WIDTH cycles
// FINAL | conditional subtract, publish result, pulse done
module mont_mul_engine
  import mont_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             pclk,
  input  logic             nreset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = WIDTH + ACC_EXTRA;

  mont_state_e      state_q;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [AW-1:0]    acc_q, acc_d, res_d;
  logic [CNT_W-1:0] idx_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q, done_q, err_q;

  // a_q shifts right each iteration, so a_q[0] is always the current a bit.
  mont_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .a_bit_i(a_q[0]),
    .b_i    (b_q),
    .m_i    (m_q),
    .acc_o  (acc_d)
  );

  // acc < 2m after RUN, so a single subtraction fully reduces it.
  always_comb begin
    res_d = (acc_q >= AW'(m_q)) ? (acc_q - AW'(m_q)) : acc_q;
  end

  always_ff @(posedge pclk) begin
    if (!nreset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            acc_q <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
            if (!m[0]) begin
              err_q    <= 1'b1;
              result_q <= '0;
              done_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            a_q   <= a_q >> 1;
            idx_q <= idx_q + CNT_W'(1);
            if (idx_q == CNT_W'(WIDTH - 1)) state_q <= FINAL;
          end
        end
        FINAL: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!abort) begin
            result_q <= WIDTH'(res_d);
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mont_mul_engine.sv
// Bench for mont_mul_engine at WIDTH 8, 64 and 256 against a modular-arithmetic
// model with a transaction-level timing model.
`timescale 1ns/1ps
module tb_mont_mul_engine;

  localparam int NI = 3;
  localparam int MW = 600;

  logic pclk = 1'b0;
  logic nreset;
  logic st  [NI];
  logic ab  [NI];
  logic bsy [NI];
  logic dn  [NI];
  logic er  [NI];

  logic [7:0]   a8,   b8,   m8,   r8;
  logic [63:0]  a64,  b64,  m64,  r64;
  logic [255:0] a256, b256, m256, r256;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  int            rem    [NI];
  logic [MW-1:0] pend   [NI];
  logic [MW-1:0] e_res  [NI];
  logic          e_done [NI];
  logic          e_err  [NI];

  always #5 pclk = ~pclk;

  mont_mul_engine #(.WIDTH(8)) u8 (
    .pclk(pclk), .nreset(nreset), .start(st[0]), .abort(ab[0]),
    .a(a8), .b(b8), .m(m8), .result(r8),
    .busy(bsy[0]), .done(dn[0]), .err(er[0]));

  mont_mul_engine #(.WIDTH(64)) u64 (
    .pclk(pclk), .nreset(nreset), .start(st[1]), .abort(ab[1]),
    .a(a64), .b(b64), .m(m64), .result(r64),
    .busy(bsy[1]), .done(dn[1]), .err(er[1]));

  mont_mul_engine #(.WIDTH(256)) u256 (
    .pclk(pclk), .nreset(nreset), .start(st[2]), .abort(ab[2]),
    .a(a256), .b(b256), .m(m256), .result(r256),
    .busy(bsy[2]), .done(dn[2]), .err(er[2]));

  function automatic int wid(input int i);
    return (i == 0) ? 8 : (i == 1) ? 64 : 256;
  endfunction

  function automatic logic [MW-1:0] get_a(input int i);
    return (i == 0) ? MW'(a8) : (i == 1) ? MW'(a64) : MW'(a256);
  endfunction
  function automatic logic [MW-1:0] get_b(input int i);
    return (i == 0) ? MW'(b8) : (i == 1) ? MW'(b64) : MW'(b256);
  endfunction
  function automatic logic [MW-1:0] get_m(input int i);
    return (i == 0) ? MW'(m8) : (i == 1) ? MW'(m64) : MW'(m256);
  endfunction
  function automatic logic [MW-1:0] get_res(input int i);
    return (i == 0) ? MW'(r8) : (i == 1) ? MW'(r64) : MW'(r256);
  endfunction

  // a*b*2^-w mod m: reduce the product, then halve modulo m w times.
  function automatic logic [MW-1:0] mont_ref(input logic [MW-1:0] av, input logic [MW-1:0] bv,
                                             input logic [MW-1:0] mv, input int w);
    logic [MW-1:0] x;
    x = (av * bv) % mv;
    for (int k = 0; k < w; k++) x = (x % 2 == 1) ? ((x + mv) >> 1) : (x >> 1);
    return x;
  endfunction

  function automatic logic [MW-1:0] rnd(input int w);
    logic [MW-1:0] v;
    v = '0;
    for (int k = 0; k < (w + 31) / 32; k++) v = (v << 32) | MW'($urandom);
    return v & ((MW'(1) << w) - MW'(1));
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transaction-level model: an accepted start opens a WIDTH+1 cycle busy window.
  always @(posedge pclk) begin
    for (int i = 0; i < NI; i++) begin
      if (!nreset) begin
        rem[i]    <= 0;
        e_res[i]  <= '0;
        e_done[i] <= 1'b0;
        e_err[i]  <= 1'b0;
      end else if (rem[i] == 0) begin
        e_done[i] <= 1'b0;
        if (st[i] && !ab[i]) begin
          if (get_m(i) % 2 == 0) begin
            e_err[i]  <= 1'b1;
            e_res[i]  <= '0;
            e_done[i] <= 1'b1;
          end else begin
            e_err[i] <= 1'b0;
            rem[i]   <= wid(i) + 1;
            pend[i]  <= mont_ref(get_a(i), get_b(i), get_m(i), wid(i));
          end
        end
      end else if (ab[i]) begin
        rem[i]    <= 0;
        e_done[i] <= 1'b0;
      end else begin
        rem[i]    <= rem[i] - 1;
        e_done[i] <= (rem[i] == 1);
        if (rem[i] == 1) e_res[i] <= pend[i];
      end
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("busy_w%0d", wid(i)),   MW'(bsy[i]), MW'(rem[i] != 0));
        chk($sformatf("done_w%0d", wid(i)),   MW'(dn[i]),  MW'(e_done[i]));
        chk($sformatf("err_w%0d", wid(i)),    MW'(er[i]),  MW'(e_err[i]));
        chk($sformatf("result_w%0d", wid(i)), get_res(i),  e_res[i]);
      end
    end
  end

  task automatic set_ops(input int i, input logic [MW-1:0] av, input logic [MW-1:0] bv,
                         input logic [MW-1:0] mv);
    case (i)
      0:       begin a8   = av[7:0];   b8   = bv[7:0];   m8   = mv[7:0];   end
      1:       begin a64  = av[63:0];  b64  = bv[63:0];  m64  = mv[63:0];  end
      default: begin a256 = av[255:0]; b256 = bv[255:0]; m256 = mv[255:0]; end
    endcase
  endtask

  task automatic go(input int i, input logic [MW-1:0] av, input logic [MW-1:0] bv,
                    input logic [MW-1:0] mv);
    set_ops(i, av, bv, mv);
    st[i] = 1'b1;
    @(negedge pclk);
    st[i] = 1'b0;
  endtask

  // Called just after the start edge; lat counts edges since that edge.
  task automatic wait_done(input int i, input int poke, output int lat, output int nbusy);
    lat   = -1;
    nbusy = 0;
    for (int k = 0; k <= wid(i) + 4; k++) begin
      if (k > 0) @(negedge pclk);
      if (bsy[i]) nbusy++;
      if (dn[i]) begin
        lat = k;
        break;
      end
      if (k == poke) begin
        set_ops(i, 1, 2, 11);
        st[i] = 1'b1;
      end else begin
        st[i] = 1'b0;
      end
    end
    st[i] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] av, bv, mv, m64max;
    int lat, nb, nd;
    nreset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      st[i] = 1'b0;
      ab[i] = 1'b0;
      set_ops(i, 0, 0, 1);
    end
    repeat (2) @(negedge pclk);
    chk_en = 1'b1;
    chk("reset_result", get_res(0), 0);
    chk("reset_busy", MW'(bsy[0]), 0);
    nreset = 1'b1;
    @(negedge pclk);

    m64max = MW'(64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_5x7_m13", mont_ref(5, 7, 13, 8), 1);
    chk("pin_3x4_m13", mont_ref(3, 4, 13, 8), 10);
    chk("pin_3x5_m64max", mont_ref(3, 5, m64max, 64), 15);
    chk("pin_neg1sq_m64max", mont_ref(m64max - 1, m64max - 1, m64max, 64), 1);

    // Basic WIDTH=8 product
    go(0, 5, 7, 13);
    wait_done(0, -1, lat, nb);
    chk("w8_latency", lat, 9);
    chk("w8_busy_cycles", nb, 9);
    chk("w8_result", get_res(0), 1);

    // WIDTH=64 with all-ones modulus
    go(1, 3, 5, m64max);
    wait_done(1, -1, lat, nb);
    chk("w64_latency", lat, 65);
    chk("w64_result_15", get_res(1), 15);
    go(1, m64max - 1, m64max - 1, m64max);
    wait_done(1, -1, lat, nb);
    chk("w64_result_1", get_res(1), 1);

    // Even modulus
    go(0, 5, 7, 12);
    wait_done(0, -1, lat, nb);
    chk("even_latency", lat, 0);
    chk("even_busy_cycles", nb, 0);
    chk("even_err", MW'(er[0]), 1);
    chk("even_result", get_res(0), 0);
    go(0, 3, 4, 13);
    chk("err_cleared", MW'(er[0]), 0);
    wait_done(0, -1, lat, nb);
    chk("w8_result_10", get_res(0), 10);

    // Abort in RUN, then immediate restart
    go(0, 5, 7, 13);
    repeat (3) @(negedge pclk);
    ab[0] = 1'b1;
    @(negedge pclk);
    ab[0] = 1'b0;
    chk("abort_busy", MW'(bsy[0]), 0);
    chk("abort_result_held", get_res(0), 10);
    go(0, 5, 7, 13);
    wait_done(0, -1, lat, nb);
    chk("restart_latency", lat, 9);
    chk("restart_result", get_res(0), 1);

    // Abort beats start in IDLE
    set_ops(0, 3, 4, 13);
    st[0] = 1'b1;
    ab[0] = 1'b1;
    @(negedge pclk);
    st[0] = 1'b0;
    ab[0] = 1'b0;
    chk("abort_start_busy", MW'(bsy[0]), 0);

    // Back-to-back with ignored starts while busy
    go(0, 3, 4, 13);
    wait_done(0, 3, lat, nb);
    chk("b2b1_latency", lat, 9);
    chk("b2b1_result", get_res(0), 10);
    go(0, 6, 9, 13);
    wait_done(0, 5, lat, nb);
    chk("b2b2_latency", lat, 9);
    chk("b2b2_result", get_res(0), 6);
    go(0, 12, 12, 13);
    wait_done(0, -1, lat, nb);
    chk("b2b3_latency", lat, 9);
    chk("b2b3_result", get_res(0), 3);
    nd = 0;
    repeat (12) begin
      @(negedge pclk);
      if (dn[0]) nd++;
    end
    chk("b2b_no_extra_done", nd, 0);

    // Reset mid-RUN clears everything, including another instance's err
    go(1, 5, 7, 12);
    wait_done(1, -1, lat, nb);
    chk("w64_even_err", MW'(er[1]), 1);
    go(0, 5, 7, 13);
    repeat (4) @(negedge pclk);
    nreset = 1'b0;
    @(negedge pclk);
    nreset = 1'b1;
    chk("rst_mid_result", get_res(0), 0);
    chk("rst_mid_busy", MW'(bsy[0]), 0);
    chk("rst_mid_done", MW'(dn[0]), 0);
    chk("rst_mid_err_w64", MW'(er[1]), 0);
    chk("rst_mid_result_w64", get_res(1), 0);
    repeat (12) @(negedge pclk);

    // Random odd moduli with a, b < m; every tenth run uses a = b = m-1
    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < ((i == 0) ? 200 : (i == 1) ? 100 : 30); r++) begin
        mv = rnd(wid(i)) | MW'(1);
        if (mv < 3) mv = 3;
        av = rnd(wid(i)) % mv;
        bv = rnd(wid(i)) % mv;
        if (r % 10 == 9) begin
          av = mv - 1;
          bv = mv - 1;
        end
        go(i, av, bv, mv);
        wait_done(i, -1, lat, nb);
        chk($sformatf("rand_w%0d_latency", wid(i)), lat, wid(i) + 1);
      end
    end

    repeat (3) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
